// File: rtl/fan_speed.sv
// fan_speed: 256-clock PWM fan drive, duty applied only at period boundaries.
// Define FAN_SPEED_SOFTSTART_EN to ramp duty increases by RAMP_STEP per period.
module fan_speed #(
  parameter int unsigned RAMP_STEP = 16
) (
  input  logic       arst,
  input  logic       clk,
  input  logic [7:0] speed,
  output logic       pwm_data
);

  logic [7:0] cnt_q;
  logic [7:0] cnt_d;
  logic [7:0] duty_q;
  logic [7:0] duty_d;
  logic [7:0] speed_eff;
  logic       pwm_q;
  logic       pwm_d;
  logic       boundary;

  if (RAMP_STEP < 1 || RAMP_STEP > 255) begin : g_bad_step
    $error("fan_speed: RAMP_STEP must be 1..255");
  end

`ifdef FAN_SPEED_SOFTSTART_EN
  logic [8:0] ramp_sum;

  // Step toward a higher speed with saturation; drop instantly otherwise.
  always_comb begin
    ramp_sum  = {1'b0, duty_q} + 9'(RAMP_STEP);
    speed_eff = speed;
    if (speed > duty_q && ramp_sum < {1'b0, speed}) begin
      speed_eff = ramp_sum[7:0];
    end
  end
`else
  assign speed_eff = speed;
`endif

  assign boundary = (cnt_q == 8'hFF);

  // Next counter, next duty and registered compare against both.
  always_comb begin
    cnt_d  = cnt_q + 8'd1;
    duty_d = duty_q;
    if (boundary) begin
      duty_d = speed_eff;
    end
    pwm_d = (cnt_d < duty_d);
  end

  // Period counter, applied duty and output flop.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      cnt_q  <= 8'd0;
      duty_q <= 8'd0;
      pwm_q  <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      duty_q <= duty_d;
      pwm_q  <= pwm_d;
    end
  end

  assign pwm_data = pwm_q;

endmodule

// File: tb/tb_fan_speed.sv
// tb_fan_speed: directed checks of fan_speed period, duty and reset behaviour.
// Default build (soft start disabled).
module tb_fan_speed;

  logic       arst;
  logic       clk;
  logic [7:0] speed;
  logic       pwm_data;

  int checks;
  int failures;

  fan_speed #(.RAMP_STEP(16)) dut (
    .arst     (arst),
    .clk      (clk),
    .speed    (speed),
    .pwm_data (pwm_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  // Runs one period from a negedge in the cnt==0 cycle.
  // mode 0: hold speed; 1: set chg_val at cycle chg_at; 2: toggle A0/30.
  task automatic run_period(
    input  int         mode,
    input  int         chg_at,
    input  logic [7:0] chg_val,
    output int         hi,
    output int         first,
    output int         last
  );
    hi    = 0;
    first = -1;
    last  = -1;
    for (int i = 0; i < 256; i++) begin
      if (mode == 1 && i == chg_at) speed = chg_val;
      if (mode == 2) speed = (i % 2 == 1) ? 8'hA0 : 8'h30;
      if (pwm_data === 1'b1) begin
        hi++;
        if (first < 0) first = i;
        last = i;
      end
      @(negedge clk);
    end
  endtask

  task automatic chk_period(
    input string tag,
    input int    mode,
    input int    chg_at,
    input logic [7:0] chg_val,
    input int    exp_hi
  );
    int hi;
    int first;
    int last;
    run_period(mode, chg_at, chg_val, hi, first, last);
    chk({tag, "_hi"}, hi, exp_hi);
    chk({tag, "_first"}, first, (exp_hi == 0) ? -1 : 0);
    chk({tag, "_last"}, last, exp_hi - 1);
  endtask

  initial begin
    int hi_rst;
    checks   = 0;
    failures = 0;
    speed    = 8'h40;
    arst     = 1'b1;
    #1 arst  = 1'b0;

    // Held reset: output stays low.
    hi_rst = 0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (pwm_data !== 1'b0) hi_rst++;
    end
    chk("rst_hold_hi", hi_rst, 0);

    arst = 1'b1;
    chk_period("first", 0, 0, 8'h00, 0);
    chk_period("nom1", 0, 0, 8'h00, 64);
    chk_period("nom2", 0, 0, 8'h00, 64);

    // Mid-period change waits for the boundary.
    chk_period("midchg", 1, 100, 8'hC0, 64);
    chk_period("after", 0, 0, 8'h00, 192);

    // Extremes.
    chk_period("pre_ff", 1, 3, 8'hFF, 192);
    chk_period("full", 0, 0, 8'h00, 255);
    chk_period("pre_00", 1, 0, 8'h00, 255);
    chk_period("zero1", 0, 0, 8'h00, 0);
    chk_period("zero2", 0, 0, 8'h00, 0);

    // Toggling speed: only the cnt==255 value (A0) matters.
    chk_period("tog1", 2, 0, 8'h00, 0);
    chk_period("tog2", 2, 0, 8'h00, 160);
    chk_period("tog3", 2, 0, 8'h00, 160);
    chk_period("hold", 0, 0, 8'h00, 160);

    // Async reset mid-pulse.
    repeat (10) @(negedge clk);
    chk("pulse_high", int'(pwm_data), 1);
    #1 arst = 1'b0;
    #1 chk("async_clr", int'(pwm_data), 0);
    @(negedge clk);
    chk("rst_hold2", int'(pwm_data), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
